// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-channel TDM receiver: channel indices
// (same encoding as the transmitter's mux4 select) and FSM state encoding.
package tdm_demux4_pkg;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_demux4_demux4.sv
// demux4: 2-to-4 one-hot decoder, the structural inverse of the transmitter's
// mux4. Turns a channel index into per-channel write enables.
module demux4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] onehot
);

    // Decode the channel index into a single enable bit when en is set.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        onehot = 4'b0000;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receiving end of a 4-channel TDM link. Recovers frame alignment
// from the start-of-frame marker, collects channels a..c into shadow registers
// and publishes the whole frame on the channel-d beat with a one-cycle strobe.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_sof,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [W-1:0] out_c,
    output logic [W-1:0] out_d,
    output logic         out_valid,
    output logic [1:0]   sel,
    output logic         locked,
    output logic         sync_err
);

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    logic         sync_err_q, sync_err_d;

    logic         wr_en;
    logic [1:0]   wr_idx;
    logic [3:0]   we;

    logic [W-1:0] shadow_a_q, shadow_b_q, shadow_c_q;
    logic [W-1:0] out_a_q, out_b_q, out_c_q, out_d_q;

    // Next-state, beat-routing and strobe decisions for each incoming beat.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en       = 1'b0;
        wr_idx      = cnt_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    // Non-SOF beats are dropped silently while hunting.
                    if (in_sof) begin
                        wr_en   = 1'b1;
                        wr_idx  = CH_A;
                        cnt_d   = CH_B;
                        state_d = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (in_sof) begin
                        // SOF always restarts the frame; mid-frame it is an error
                        // and the partial frame is abandoned.
                        wr_en      = 1'b1;
                        wr_idx     = CH_A;
                        cnt_d      = CH_B;
                        sync_err_d = (cnt_q != CH_A);
                    end else if (cnt_q == CH_A) begin
                        // Expected SOF did not arrive: alignment lost.
                        sync_err_d = 1'b1;
                        state_d    = ST_HUNT;
                        cnt_d      = CH_A;
                    end else begin
                        // Channel b, c or d; the d write enable publishes the frame.
                        wr_en       = 1'b1;
                        cnt_d       = cnt_q + 2'd1;
                        out_valid_d = (cnt_q == CH_D);
                    end
                end
                default: ;
            endcase
        end
    end

    demux4 u_demux4 (
        .sel    (wr_idx),
        .en     (wr_en),
        .onehot (we)
    );

    // Control registers: FSM state, channel counter and the two strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            cnt_q       <= CH_A;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Datapath: shadow capture for a..c and frame publication on the d beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: shadow and output registers are reset too; outputs must read 0 after reset.
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            shadow_c_q <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            out_c_q    <= '0;
            out_d_q    <= '0;
        end else begin
            if (we[CH_A]) shadow_a_q <= in_data;
            if (we[CH_B]) shadow_b_q <= in_data;
            if (we[CH_C]) shadow_c_q <= in_data;
            if (we[CH_D]) begin
                out_a_q <= shadow_a_q;
                out_b_q <= shadow_b_q;
                out_c_q <= shadow_c_q;
                out_d_q <= in_data;
            end
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign sel       = cnt_q;
    assign locked    = (state_q == ST_LOCK);

endmodule
